// File: rtl/skeleton_feeder.sv
// skeleton_feeder: thresholds and decimates one camera frame into a 1-bit mask,
// then replays it as a gap-free raster stream into the skeletonizer.
module skeleton_feeder #(
  parameter int CAM_HRES = 1280,
  parameter int CAM_VRES = 720,
  parameter int SCALE_SHIFT = 2,
  parameter int HORIZONTAL_COUNT = CAM_HRES >> SCALE_SHIFT,
  parameter int VERTICAL_COUNT = CAM_VRES >> SCALE_SHIFT,
  localparam int HWIDTH = $clog2(HORIZONTAL_COUNT),
  localparam int VWIDTH = $clog2(VERTICAL_COUNT),
  localparam int CHW = $clog2(CAM_HRES),
  localparam int CVW = $clog2(CAM_VRES)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [CHW-1:0]    cam_hcount_in,
  input  logic [CVW-1:0]    cam_vcount_in,
  input  logic [7:0]        cam_luma_in,
  input  logic              cam_valid_in,
  input  logic [7:0]        threshold_in,
  input  logic              skel_busy_in,
  output logic [HWIDTH-1:0] hcount_out,
  output logic [VWIDTH-1:0] vcount_out,
  output logic              pixel_out,
  output logic              pixel_valid_out,
  output logic              capturing_out,
  output logic [15:0]       frames_dropped_out
);

  localparam int N = HORIZONTAL_COUNT * VERTICAL_COUNT;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int STEP = 1 << SCALE_SHIFT;
  localparam logic [CHW-1:0] CAM_H_LAST = CHW'(CAM_HRES - STEP);
  localparam logic [CVW-1:0] CAM_V_LAST = CVW'(CAM_VRES - STEP);
  localparam logic [CHW-1:0] CAM_H_SUB = CHW'(STEP - 1);
  localparam logic [CVW-1:0] CAM_V_SUB = CVW'(STEP - 1);
  localparam logic [HWIDTH-1:0] H_LAST = HWIDTH'(HORIZONTAL_COUNT - 1);
  localparam logic [VWIDTH-1:0] V_LAST = VWIDTH'(VERTICAL_COUNT - 1);

  typedef enum logic [2:0] {
    IDLE, CAPTURE, READY, STREAM, DRAIN
  } state_t;

  state_t state_q, state_d;

  logic frame_start, sample, cap_last;
  logic wr_en, wr_data, thr_ld, rd_en, last_issue;
  logic [7:0] thr_q, thr_eff;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [HWIDTH-1:0] rd_h, h1, h2;
  logic [VWIDTH-1:0] rd_v, vc1, vc2;
  logic [15:0] drop_q;
  logic mem [N];
  logic mem_q, doutb;
  logic v1, v2;

  assign frame_start = cam_valid_in
                    && cam_hcount_in == '0
                    && cam_vcount_in == '0;
  assign sample = cam_valid_in
               && (cam_hcount_in & CAM_H_SUB) == '0
               && (cam_vcount_in & CAM_V_SUB) == '0;
  assign cap_last = sample
                 && cam_hcount_in == CAM_H_LAST
                 && cam_vcount_in == CAM_V_LAST;

  assign wr_addr = AW'((int'(cam_vcount_in) >> SCALE_SHIFT)
                 * HORIZONTAL_COUNT
                 + (int'(cam_hcount_in) >> SCALE_SHIFT));
  assign wr_data = cam_luma_in >= thr_eff;
  assign rd_addr = AW'(int'(rd_v) * HORIZONTAL_COUNT + int'(rd_h));
  assign last_issue = rd_h == H_LAST && rd_v == V_LAST;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    thr_ld  = 1'b0;
    rd_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          thr_ld  = 1'b1;
          wr_en   = 1'b1;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        thr_ld = frame_start;
        wr_en  = sample;
        if (cap_last) state_d = READY;
      end
      READY: begin
        if (!skel_busy_in) state_d = STREAM;
      end
      STREAM: begin
        rd_en = 1'b1;
        if (last_issue) state_d = DRAIN;
      end
      DRAIN: begin
        if (!v1 && !v2) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // a restarting frame start must compare against the fresh threshold
  assign thr_eff = thr_ld ? threshold_in : thr_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      thr_q  <= '0;
      drop_q <= '0;
    end else begin
      if (thr_ld) thr_q <= threshold_in;
      if (frame_start && state_q != IDLE && drop_q != 16'hFFFF)
        drop_q <= drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd_h <= '0;
      rd_v <= '0;
    end else if (state_q == READY || (rd_en && last_issue)) begin
      rd_h <= '0;
      rd_v <= '0;
    end else if (rd_en) begin
      if (rd_h == H_LAST) begin
        rd_h <= '0;
        rd_v <= rd_v + 1'b1;
      end else begin
        rd_h <= rd_h + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    mem_q <= mem[rd_addr];
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      doutb           <= 1'b0;
      v1              <= 1'b0;
      v2              <= 1'b0;
      h1              <= '0;
      h2              <= '0;
      vc1             <= '0;
      vc2             <= '0;
      pixel_valid_out <= 1'b0;
      pixel_out       <= 1'b0;
      hcount_out      <= '0;
      vcount_out      <= '0;
    end else begin
      doutb           <= mem_q;
      v1              <= rd_en;
      v2              <= v1;
      h1              <= rd_h;
      h2              <= h1;
      vc1             <= rd_v;
      vc2             <= vc1;
      pixel_valid_out <= v2;
      if (v2) begin
        pixel_out  <= doutb;
        hcount_out <= h2;
        vcount_out <= vc2;
      end
    end
  end

  assign capturing_out      = state_q == CAPTURE;
  assign frames_dropped_out = drop_q;

endmodule

// File: doc/skeleton_feeder.md
# skeleton_feeder

Camera-side producer for the skeletonizer's binary pixel-stream input. It thresholds and decimates one camera frame of 8-bit luma into a 1-bit mask held in an internal frame buffer. When the skeletonizer deasserts `busy`, it replays that mask as a gap-free raster stream on the skeletonizer's `hcount/vcount/pixel/valid` input interface. It sits between the camera pixel pipeline and `skeletonizer`. It drops camera frames while a mask is pending or streaming.

## Interface
- `CAM_HRES`, 1280, camera active width
- `CAM_VRES`, 720, camera active height
- `SCALE_SHIFT`, 2, decimation factor `2**SCALE_SHIFT` in each axis
- `HORIZONTAL_COUNT`, `CAM_HRES>>SCALE_SHIFT`, mask width
- `VERTICAL_COUNT`, `CAM_VRES>>SCALE_SHIFT`, mask height
- HWIDTH = `$clog2(HORIZONTAL_COUNT)`, VWIDTH = `$clog2(VERTICAL_COUNT)`, N = `HORIZONTAL_COUNT*VERTICAL_COUNT`

Ports:
- `clk_in` in 1: single clock
- `rst_n_in` in 1: reset, asynchronous, active-low
- `cam_hcount_in` in `$clog2(CAM_HRES)`: camera x
- `cam_vcount_in` in `$clog2(CAM_VRES)`: camera y
- `cam_luma_in` in 8: camera luma
- `cam_valid_in` in 1: camera pixel valid
- `threshold_in` in 8: mask threshold, latched at capture start
- `skel_busy_in` in 1: skeletonizer `busy`
- `hcount_out` out HWIDTH: mask x
- `vcount_out` out VWIDTH: mask y
- `pixel_out` out 1: mask bit
- `pixel_valid_out` out 1: mask pixel valid
- `capturing_out` out 1: high in CAPTURE
- `frames_dropped_out` out 16: saturating dropped-frame count

## Operation
- **States:** IDLE, CAPTURE, READY, STREAM, DRAIN.
- **Frame start:** `cam_valid_in` with `cam_hcount_in==0 && cam_vcount_in==0`.
- **Sample pixel:** `cam_valid_in` with the low SCALE_SHIFT bits of both camera counts equal to zero.
  - Write address = `(cam_vcount_in>>S)*HORIZONTAL_COUNT + (cam_hcount_in>>S)`.
  - Write data = `cam_luma_in >= thr_q` (unsigned compare).
- **IDLE:** on a frame start, latch `threshold_in` into `thr_q` and go to CAPTURE.
  - The frame-start pixel is written in that same cycle, using the new threshold.
- **CAPTURE:** write every sample pixel.
  - Writing the last sample (camera x = `CAM_HRES-2**S`, y = `CAM_VRES-2**S`) goes to READY.
  - A frame start before completion counts as a drop, re-latches the threshold and restarts CAPTURE, writing address 0.
- **READY:** in any cycle with `skel_busy_in==0`, clear the read counters and go to STREAM.
- **STREAM:** issue one read address per cycle in raster order `rd_h`, `rd_v`.
  - `rd_h` wraps at `HORIZONTAL_COUNT-1` and increments `rd_v`.
  - The cycle that issues (`H-1`, `V-1`) goes to DRAIN.
  - `skel_busy_in` is ignored here. Streaming is never paused.
- **DRAIN:** hold until the last pixel has left the output register, then go to IDLE.
- **Drops:** each frame start observed in READY, STREAM or DRAIN increments `frames_dropped_out`, saturating at 16'hFFFF.
  - Simultaneous frame start with READY→STREAM: the transition happens and the frame counts as dropped.
- **Frame buffer:** 1-bit × N dual-port BRAM, with 2-cycle read latency and high-performance output register.
  - Port A is capture write only; port B is stream read only.
- **Output register:** updated every cycle.
  - `pixel_valid_out` is the delayed valid.
  - `hcount_out`/`vcount_out` are the read counters delayed to align with the data.
  - `pixel_out` is BRAM `doutb`.
  - When not valid, `pixel_valid_out=0` and the other outputs hold.

## Timing
- **Reset (async assert):** state IDLE, all outputs 0, read pipeline valids cleared, counters 0.
  - Frame buffer contents are not cleared.
- Reset mid-CAPTURE or mid-STREAM aborts immediately. No partial stream continues after release.
- **Read latency:** address issued in cycle t gives `pixel_valid_out`, coordinates and data in cycle t+3.
- **Stream shape:** first valid 4 cycles after the READY cycle that saw busy low, then exactly N consecutive valid cycles with no gaps.
- **Frame-start pixels:** the first output pixel is (0,0) and the last is (`H-1`, `V-1`).
  - The skeletonizer raises `busy` the cycle after receiving (`H-1`, `V-1`).
- DRAIN lasts 3 cycles.
- **Capture rate:** one write per camera cycle at most.
- Earliest re-capture is the next frame start after IDLE is re-entered.
- Counter widths are exact. No arithmetic overflow is permitted beyond the saturating drop counter.

## Test plan
Use `CAM_HRES=16`, `CAM_VRES=8`, `SCALE_SHIFT=2` (4×2 mask, N=8) unless stated otherwise.
- **Basic capture/stream:** luma = 16×camera x, `threshold_in=100`, busy held 0.
  - Expect 8 consecutive valids; pixels per row 0,0,1,1 (x=0,4,8,12); coords raster (0,0)…(3,1).
  - First valid exactly 4 cycles after entering READY.
- **Busy hold-off:** busy=1 through capture, released 50 cycles after READY.
  - Expect no valid while busy is high; stream starts 4 cycles after release.
- **Threshold latching:** change `threshold_in` from 100 to 255 mid-capture.
  - Expect the mask still uses 100.
- **Drops:** keep busy high and send 3 further frames.
  - Expect `frames_dropped_out=3` and the original mask streamed afterwards.
  - A separate run forces the counter to 16'hFFFE; expect it to saturate at 16'hFFFF.
- **Truncated frame:** frame start at camera row 4 mid-capture.
  - Expect drop count 1, capture restarted, and the streamed mask equal to the second frame.
- **Async reset mid-STREAM:** assert `rst_n_in` low after 3 valids.
  - Expect `pixel_valid_out` 0 immediately and IDLE after release.
  - The next full frame streams N correct pixels.
